// File: rtl/line_io_frontend.sv
// Correlator input front end: synchronises and conditions the header lines, offers
// test-pattern / loopback / hold modes, and drives activity LEDs, power enables and stuck flags.
module line_io_frontend #(
  parameter int NUM_LINES     = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int LED_STRETCH   = 1330000,
  parameter int STUCK_CYCLES  = 13300000,
  parameter int HAS_LED_FLAGS = 1,
  parameter int HAS_PSU       = 0
) (
  input  logic                   clki,
  input  logic                   rst_n,
  input  logic [NUM_LINES-1:0]   pad_in,
  input  logic                   cfg_strobe,
  input  logic [1:0]             cfg_mode,
  input  logic [NUM_LINES-1:0]   cfg_enable,
  input  logic [NUM_LINES-1:0]   cfg_invert,
  output logic [NUM_LINES-1:0]   line_in,
  output logic [3*NUM_LINES-1:0] line_out,
  output logic [NUM_LINES-1:0]   stuck
);

  localparam int CNT_MAX = (LED_STRETCH > STUCK_CYCLES) ? LED_STRETCH : STUCK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LED_LOAD  = CW'(LED_STRETCH);
  localparam logic [CW-1:0] STUCK_SAT = CW'(STUCK_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;
  localparam logic          LED_ON    = (HAS_LED_FLAGS != 0);
  localparam logic          PSU_ON    = (HAS_PSU != 0);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_TEST   = 2'b01,
    MODE_LOOP   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e                  mode_q, mode_d;
  logic [NUM_LINES-1:0]   enable_q, enable_d, invert_q, invert_d;
  logic [NUM_LINES-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_LINES-1:0]   sync_d [SYNC_STAGES];
  logic [NUM_LINES-1:0]   s_prev_q, s_prev_d, t_prev_q, t_prev_d;
  logic [NUM_LINES-1:0]   line_in_q, line_in_d, stuck_q, stuck_d;
  logic [3*NUM_LINES-1:0] line_out_q, line_out_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [CW-1:0]          led_cnt_q [NUM_LINES];
  logic [CW-1:0]          led_cnt_d [NUM_LINES];
  logic [CW-1:0]          stk_cnt_q [NUM_LINES];
  logic [CW-1:0]          stk_cnt_d [NUM_LINES];

  logic [NUM_LINES-1:0]   s_s, edge_s, t_s;
  logic                   lfsr_fb_s;

  // Configuration latch, synchroniser chain and LFSR sequencing
  always_comb begin
    if (cfg_strobe) begin
      mode_d   = mode_e'(cfg_mode);
      enable_d = cfg_enable;
      invert_d = cfg_invert;
    end else begin
      mode_d   = mode_q;
      enable_d = enable_q;
      invert_d = invert_q;
    end

    sync_d[0] = pad_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end

    // Taps at bits 0,2,3,5 realise x^16+x^14+x^13+x^11+1 in a right-shifting register
    lfsr_fb_s = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    if (cfg_strobe && (cfg_mode == 2'b01) && (mode_q != MODE_TEST)) begin
      lfsr_d = LFSR_SEED;
    end else if (mode_q == MODE_TEST) begin
      lfsr_d = {lfsr_fb_s, lfsr_q[15:1]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // Line datapath, activity/stuck counters and registered output images
  always_comb begin
    s_s      = sync_q[SYNC_STAGES-1] ^ invert_q;
    edge_s   = s_s ^ s_prev_q;
    s_prev_d = s_s;
    for (int i = 0; i < NUM_LINES; i++) begin
      if ((mode_q == MODE_TEST) || (mode_q == MODE_LOOP)) begin
        t_s[i] = lfsr_q[i % 16];
      end else begin
        t_s[i] = 1'b0;
      end
    end
    t_prev_d = t_s;

    case (mode_q)
      MODE_NORMAL: line_in_d = s_s & enable_q;
      MODE_TEST:   line_in_d = t_s & enable_q;
      MODE_LOOP:   line_in_d = t_prev_q & enable_q;
      MODE_HOLD:   line_in_d = line_in_q;
      default:     line_in_d = line_in_q;
    endcase

    line_out_d = {(3*NUM_LINES){1'b0}};
    stuck_d    = {NUM_LINES{1'b0}};
    for (int i = 0; i < NUM_LINES; i++) begin
      if (!enable_q[i]) begin
        led_cnt_d[i] = CNT_ZERO;
        stk_cnt_d[i] = CNT_ZERO;
      end else if (edge_s[i]) begin
        led_cnt_d[i] = LED_LOAD;
        stk_cnt_d[i] = CNT_ZERO;
      end else begin
        led_cnt_d[i] = (led_cnt_q[i] != CNT_ZERO) ? (led_cnt_q[i] - CW'(1)) : CNT_ZERO;
        stk_cnt_d[i] = (stk_cnt_q[i] == STUCK_SAT) ? STUCK_SAT : (stk_cnt_q[i] + CW'(1));
      end
      stuck_d[i]                   = enable_q[i] && (stk_cnt_d[i] == STUCK_SAT);
      line_out_d[i]                = LED_ON && (led_cnt_d[i] != CNT_ZERO);
      line_out_d[NUM_LINES+2*i]    = enable_q[i] && PSU_ON;
      line_out_d[NUM_LINES+2*i+1]  = t_s[i];
    end
  end

  // State registers
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_NORMAL;
      enable_q   <= {NUM_LINES{1'b0}};
      invert_q   <= {NUM_LINES{1'b0}};
      s_prev_q   <= {NUM_LINES{1'b0}};
      t_prev_q   <= {NUM_LINES{1'b0}};
      line_in_q  <= {NUM_LINES{1'b0}};
      stuck_q    <= {NUM_LINES{1'b0}};
      line_out_q <= {(3*NUM_LINES){1'b0}};
      lfsr_q     <= LFSR_SEED;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {NUM_LINES{1'b0}};
      end
      for (int i = 0; i < NUM_LINES; i++) begin
        led_cnt_q[i] <= CNT_ZERO;
        stk_cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      mode_q     <= mode_d;
      enable_q   <= enable_d;
      invert_q   <= invert_d;
      s_prev_q   <= s_prev_d;
      t_prev_q   <= t_prev_d;
      line_in_q  <= line_in_d;
      stuck_q    <= stuck_d;
      line_out_q <= line_out_d;
      lfsr_q     <= lfsr_d;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < NUM_LINES; i++) begin
        led_cnt_q[i] <= led_cnt_d[i];
        stk_cnt_q[i] <= stk_cnt_d[i];
      end
    end
  end

  assign line_in  = line_in_q;
  assign line_out = line_out_q;
  assign stuck    = stuck_q;

endmodule

// File: tb/tb_line_io_frontend.sv
// Self-checking bench for line_io_frontend: directed scenarios plus random traffic, all
// checked against a per-cycle behavioural model of the line rules.
module tb_line_io_frontend;
  localparam int N  = 8;
  localparam int S  = 2;
  localparam int L  = 20;
  localparam int ST = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   pad_in, cfg_enable, cfg_invert;
  logic           cfg_strobe;
  logic [1:0]     cfg_mode;
  logic [N-1:0]   line_in, stuck, line_in2, stuck2;
  logic [3*N-1:0] line_out, line_out2;

  int checks = 0;
  int errors = 0;

  line_io_frontend #(.NUM_LINES(N), .SYNC_STAGES(S), .LED_STRETCH(L), .STUCK_CYCLES(ST),
                     .HAS_LED_FLAGS(1), .HAS_PSU(1)) dut (
    .clki(clk), .rst_n(rst_n), .pad_in(pad_in), .cfg_strobe(cfg_strobe), .cfg_mode(cfg_mode),
    .cfg_enable(cfg_enable), .cfg_invert(cfg_invert), .line_in(line_in), .line_out(line_out),
    .stuck(stuck));

  line_io_frontend #(.NUM_LINES(N), .SYNC_STAGES(S), .LED_STRETCH(L), .STUCK_CYCLES(ST),
                     .HAS_LED_FLAGS(0), .HAS_PSU(0)) dut2 (
    .clki(clk), .rst_n(rst_n), .pad_in(pad_in), .cfg_strobe(cfg_strobe), .cfg_mode(cfg_mode),
    .cfg_enable(cfg_enable), .cfg_invert(cfg_invert), .line_in(line_in2), .line_out(line_out2),
    .stuck(stuck2));

  // Reference model state
  logic [1:0]     m_mode;
  logic [N-1:0]   m_en, m_inv, m_line_in, m_stuck, m_sprev, m_tprev;
  logic [15:0]    m_lfsr;
  logic [3*N-1:0] m_lo, m_lo2;
  int             m_led [N];
  int             m_stk [N];
  logic [N-1:0]   m_padq [$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    int   exps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (exps[k]) fb ^= l[16 - exps[k]];
    return {fb, l[15:1]};
  endfunction

  task automatic model_reset();
    m_mode = 2'd0; m_en = '0; m_inv = '0; m_line_in = '0; m_stuck = '0;
    m_sprev = '0; m_tprev = '0; m_lfsr = 16'hACE1; m_lo = '0; m_lo2 = '0;
    for (int i = 0; i < N; i++) begin m_led[i] = 0; m_stk[i] = 0; end
    m_padq.delete();
    for (int k = 0; k < S; k++) m_padq.push_back('0);
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic model_step();
    logic [N-1:0] s, e, t;
    s = m_padq[0] ^ m_inv;
    e = s ^ m_sprev;
    t = '0;
    if (m_mode == 2'd1 || m_mode == 2'd2)
      for (int i = 0; i < N; i++) t[i] = m_lfsr[i % 16];
    case (m_mode)
      2'd0:    m_line_in = s & m_en;
      2'd1:    m_line_in = t & m_en;
      2'd2:    m_line_in = m_tprev & m_en;
      default: m_line_in = m_line_in;
    endcase
    for (int i = 0; i < N; i++) begin
      if (!m_en[i]) begin
        m_led[i] = 0; m_stk[i] = 0;
      end else if (e[i]) begin
        m_led[i] = L; m_stk[i] = 0;
      end else begin
        m_led[i] = (m_led[i] > 0) ? m_led[i] - 1 : 0;
        m_stk[i] = (m_stk[i] + 1 > ST) ? ST : m_stk[i] + 1;
      end
      m_stuck[i]        = m_en[i] && (m_stk[i] == ST);
      m_lo[i]           = (m_led[i] != 0);
      m_lo[N+2*i]       = m_en[i];
      m_lo[N+2*i+1]     = t[i];
      m_lo2[i]          = 1'b0;
      m_lo2[N+2*i]      = 1'b0;
      m_lo2[N+2*i+1]    = t[i];
    end
    if (m_mode == 2'd1) m_lfsr = lfsr_next(m_lfsr);
    if (cfg_strobe) begin
      if (cfg_mode == 2'd1 && m_mode != 2'd1) m_lfsr = 16'hACE1;
      m_mode = cfg_mode; m_en = cfg_enable; m_inv = cfg_invert;
    end
    m_padq.push_back(pad_in);
    void'(m_padq.pop_front());
    m_sprev = s;
    m_tprev = t;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_strobe(input logic [1:0] md, input logic [N-1:0] en, input logic [N-1:0] inv);
    cfg_mode = md; cfg_enable = en; cfg_invert = inv; cfg_strobe = 1'b1;
    tick();
    cfg_strobe = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    checks++; if (line_in !== '0) begin errors++; $display("FAIL reset_line_in: got %h expected 0", line_in); end
    checks++; if (line_out !== '0) begin errors++; $display("FAIL reset_line_out: got %h expected 0", line_out); end
    checks++; if (stuck !== '0) begin errors++; $display("FAIL reset_stuck: got %h expected 0", stuck); end
  endtask

  task automatic test_passthrough();
    int first_li = -1, first_led = -1, led_hi = 0;
    pad_in = '0;
    do_strobe(2'd0, 8'hFF, 8'h00);
    pad_in[3] = 1'b1;
    for (int c = 1; c <= L + 10; c++) begin
      tick();
      if (line_in[3] && first_li < 0) first_li = c;
      if (line_out[3] && first_led < 0) first_led = c;
      if (line_out[3]) led_hi++;
      checks++; if (line_in !== m_line_in || line_out !== m_lo || line_out2 !== m_lo2) begin
        errors++; $display("FAIL pass_cycle%0d: got %h/%h/%h expected %h/%h/%h", c, line_in, line_out, line_out2, m_line_in, m_lo, m_lo2);
      end
    end
    checks++; if (first_li != S + 1) begin errors++; $display("FAIL pass_latency: got %0d expected %0d", first_li, S + 1); end
    checks++; if (first_led != S + 1) begin errors++; $display("FAIL led_start: got %0d expected %0d", first_led, S + 1); end
    checks++; if (led_hi != L) begin errors++; $display("FAIL led_stretch: got %0d expected %0d", led_hi, L); end
  endtask

  task automatic test_invert_enable();
    pad_in = '0;
    do_strobe(2'd0, 8'hFF, 8'h01);
    for (int c = 0; c < S + 1; c++) tick();
    checks++; if (line_in[0] !== 1'b1 || line_in !== m_line_in) begin
      errors++; $display("FAIL invert_line0: got %h expected %h", line_in, m_line_in); end
    do_strobe(2'd0, 8'hFE, 8'h01);
    tick();
    checks++; if (line_in[0] !== 1'b0 || line_out[0] !== 1'b0 || line_out !== m_lo) begin
      errors++; $display("FAIL disable_line0: got %h/%h expected 0/%h", line_in, line_out, m_lo); end
  endtask

  task automatic test_lfsr();
    logic [N-1:0] tb_bits, mask;
    mask = 8'hB7;
    do_strobe(2'd1, mask, 8'h00);
    tick();
    checks++; if (line_in !== (8'hE1 & mask)) begin
      errors++; $display("FAIL lfsr_seed: got %h expected %h", line_in, 8'hE1 & mask); end
    for (int i = 0; i < N; i++) tb_bits[i] = line_out[N+2*i+1];
    checks++; if (tb_bits !== 8'hE1) begin errors++; $display("FAIL test_drive_seed: got %h expected e1", tb_bits); end
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++; if (line_in !== m_line_in || line_out !== m_lo) begin
        errors++; $display("FAIL lfsr_cycle%0d: got %h/%h expected %h/%h", c, line_in, line_out, m_line_in, m_lo); end
    end
  endtask

  task automatic test_stuck();
    int n = 0;
    pad_in = '0;
    pulse_reset();
    do_strobe(2'd0, 8'hFF, 8'h00);
    while (!stuck[0] && n < 40) begin
      tick(); n++;
      checks++; if (stuck !== m_stuck) begin errors++; $display("FAIL stuck_track: got %h expected %h", stuck, m_stuck); end
    end
    checks++; if (n != ST) begin errors++; $display("FAIL stuck_time: got %0d expected %0d", n, ST); end
    do_strobe(2'd0, 8'hFF, 8'h01);
    checks++; if (stuck !== 8'hFF || stuck !== m_stuck) begin errors++; $display("FAIL stuck_sat: got %h expected ff", stuck); end
    tick();
    checks++; if (stuck !== 8'hFE || stuck !== m_stuck) begin errors++; $display("FAIL stuck_edge_wins: got %h expected fe", stuck); end
  endtask

  task automatic test_hold_reset();
    logic [N-1:0] frozen;
    do_strobe(2'd0, 8'hFF, 8'h00);
    for (int c = 0; c < 10; c++) begin pad_in = N'($urandom); tick(); end
    do_strobe(2'd3, 8'hFF, 8'h00);
    frozen = line_in;
    for (int c = 0; c < 20; c++) begin
      if (c % 3 == 0) pad_in[2] = ~pad_in[2];
      tick();
      checks++; if (line_in !== frozen || line_in !== m_line_in || line_out !== m_lo) begin
        errors++; $display("FAIL hold_cycle%0d: got %h/%h expected %h/%h", c, line_in, line_out, frozen, m_lo); end
    end
    checks++; if (line_out[2] !== 1'b1) begin errors++; $display("FAIL hold_led_retrigger: got %b expected 1", line_out[2]); end
    rst_n = 1'b0;
    #1;
    checks++; if (line_in !== '0 || line_out !== '0 || stuck !== '0 || line_out2 !== '0) begin
      errors++; $display("FAIL async_reset: got %h/%h/%h expected 0", line_in, line_out, stuck); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    checks++; if (line_in !== m_line_in || line_out !== m_lo || stuck !== m_stuck) begin
      errors++; $display("FAIL post_reset: got %h/%h expected %h/%h", line_in, line_out, m_line_in, m_lo); end
  endtask

  task automatic test_power();
    logic [N-1:0] p1, p2;
    do_strobe(2'd0, 8'h0F, 8'h00);
    tick();
    for (int i = 0; i < N; i++) begin p1[i] = line_out[N+2*i]; p2[i] = line_out2[N+2*i]; end
    checks++; if (p1 !== 8'h0F) begin errors++; $display("FAIL power_psu1: got %h expected 0f", p1); end
    checks++; if (p2 !== 8'h00) begin errors++; $display("FAIL power_psu0: got %h expected 00", p2); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(15, 0) == 0) begin
        cfg_strobe = 1'b1; cfg_mode = 2'($urandom);
        cfg_enable = N'($urandom); cfg_invert = N'($urandom);
      end else begin
        cfg_strobe = 1'b0;
      end
      for (int i = 0; i < N; i++) if ($urandom_range(7, 0) == 0) pad_in[i] = ~pad_in[i];
      tick();
      checks++; if (line_in !== m_line_in || line_out !== m_lo || stuck !== m_stuck || line_out2 !== m_lo2) begin
        errors++; $display("FAIL random_cycle%0d: got %h/%h/%h expected %h/%h/%h", c, line_in, line_out, stuck, m_line_in, m_lo, m_stuck); end
    end
    cfg_strobe = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pad_in = '0; cfg_strobe = 1'b0; cfg_mode = 2'd0; cfg_enable = '0; cfg_invert = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_passthrough();
    test_invert_enable();
    test_lfsr();
    test_stuck();
    test_hold_reset();
    test_power();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_io_frontend.md
LINE_IO_FRONTEND -- requirements
Module: line_io_frontend

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8: number of correlator input lines, 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, 2..4.
REQ-003 SHALL have parameter LED_STRETCH, default 1330000: activity LED hold time in cycles, at least 1.
REQ-004 SHALL have parameter STUCK_CYCLES, default 13300000: cycles without an edge before a line is flagged stuck, at least 1.
REQ-005 SHALL have parameter HAS_LED_FLAGS, default 1: 0 forces all activity LEDs low.
REQ-006 SHALL have parameter HAS_PSU, default 0: 0 forces all power-enable outputs low.
REQ-007 SHALL have port clki, input, 1 bit: the single system clock.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port pad_in, input, NUM_LINES bits: raw header inputs, asynchronous to clki.
REQ-010 SHALL have port cfg_strobe, input, 1 bit: latches cfg_mode, cfg_enable and cfg_invert.
REQ-011 SHALL have port cfg_mode, input, 2 bits: 00 normal, 01 test pattern, 10 loopback, 11 hold.
REQ-012 SHALL have port cfg_enable, input, NUM_LINES bits: per-line enable.
REQ-013 SHALL have port cfg_invert, input, NUM_LINES bits: per-line input polarity inversion.
REQ-014 SHALL have port line_in, output, NUM_LINES bits: registered samples to the correlator.
REQ-015 SHALL have port line_out, output, NUM_LINES*3 bits: bit [i] is the activity LED of line i; bit [NUM_LINES+2i] is the power enable of line i; bit [NUM_LINES+2i+1] is the test drive of line i.
REQ-016 SHALL have port stuck, output, NUM_LINES bits: per-line no-activity flag.

Function
REQ-017 SHALL load mode_r, enable_r and invert_r from cfg_* on the rising edge of clki where cfg_strobe=1; the new values take effect from the next cycle.
REQ-018 SHALL pass pad_in through SYNC_STAGES flops, then XOR the result with invert_r to form s[i].
REQ-019 SHALL detect an edge on line i when s[i] differs from the registered previous s[i].
REQ-020 SHALL implement a 16-bit LFSR with polynomial x^16+x^14+x^13+x^11+1 and seed 0xACE1.
REQ-021 SHALL step the LFSR once per cycle while mode_r=01 and hold it in all other modes.
REQ-022 SHALL reload the LFSR with the seed in the cycle mode_r changes to 01 from any other mode.
REQ-023 SHALL drive test bit t[i] = lfsr[i mod 16] when mode_r is 01 or 10, and 0 when mode_r is 00 or 11.
REQ-024 SHALL register line_in[i] each cycle as follows: mode 00 gives s[i] AND enable_r[i]; mode 01 gives t[i] AND enable_r[i]; mode 10 gives the previous cycle's t[i] AND enable_r[i] (internal loopback, no pad path); mode 11 holds the current line_in.
REQ-025 SHALL give a pad_in-to-line_in latency of SYNC_STAGES+1 cycles in mode 00.
REQ-026 SHALL keep a per-line LED counter: an edge on an enabled line loads LED_STRETCH, including a retrigger mid-count; otherwise the counter decrements while non-zero.
REQ-027 SHALL set the LED bit to (counter != 0) AND HAS_LED_FLAGS.
REQ-028 SHALL keep a per-line stuck counter: an edge clears it to 0; otherwise it increments and saturates at STUCK_CYCLES.
REQ-029 SHALL assert stuck[i] when the stuck counter equals STUCK_CYCLES and enable_r[i]=1.
REQ-030 SHALL, when enable_r[i]=0, hold both the LED counter and the stuck counter of line i at 0, so LED and stuck are 0.
REQ-031 SHALL, when an edge and saturation coincide in the same cycle, let the edge win: the counter becomes 0 and stuck deasserts the next cycle.
REQ-032 SHALL drive power enable i = enable_r[i] AND HAS_PSU, registered.
REQ-033 SHALL make mode 11 freeze line_in only; LED, stuck and LFSR-hold behaviour continue per the rules above.
REQ-034 SHALL size the counters at clog2(max(LED_STRETCH, STUCK_CYCLES)+1) bits, with no wrap-around.

Reset
REQ-035 SHALL, while rst_n=0, asynchronously clear mode_r, enable_r, invert_r, all synchroniser flops, line_in, line_out, stuck and all counters to 0, and set the LFSR to 0xACE1.
REQ-036 SHALL return to the REQ-035 state immediately on a reset asserted mid-operation, with configuration lost.
REQ-037 SHALL resume operation on the first clki edge after rst_n deasserts.

Verification
REQ-038 SHALL cover: strobe mode=00, enable=0xFF, invert=0; pad_in[3] rises -> line_in[3]=1 exactly 3 cycles later (SYNC_STAGES=2), and line_out[3]=1 for LED_STRETCH cycles.
REQ-039 SHALL cover: invert=0x01 with pad_in=0 -> line_in[0]=1 after latency; enable[0]=0 -> line_in[0]=0 and LED 0.
REQ-040 SHALL cover: mode=01 -> first line_in after entry equals seed bits 0xE1 masked by enable; the sequence matches the reference LFSR for 100 cycles; test bits appear on line_out[NUM_LINES+2i+1].
REQ-041 SHALL cover: STUCK_CYCLES=16, no edges -> stuck goes high after 16 cycles; an edge in the saturating cycle -> stuck is low the next cycle.
REQ-042 SHALL cover: mode=11 during activity -> line_in frozen while LEDs still retrigger; rst_n pulsed low mid-count -> all outputs 0 asynchronously.
REQ-043 SHALL cover: HAS_PSU=1, enable=0x0F -> power-enable bits of lines 0-3 are 1 and lines 4-7 are 0; HAS_PSU=0 -> all power-enable bits are 0.
